// File: rtl/score_sequencer.sv
// -----------------------------------------------------------------------------
// score_sequencer
//   Game-side controller for a 4-digit seven-segment score display. Keeps the
//   live score and the best score as packed 4-digit BCD, and sequences what the
//   display shows:
//     IDLE  - best score
//     PLAY  - live score, playing=1
//     FLASH - final score with the whole display blinking, then back to IDLE
//             (best score is updated on the way out if beaten).
//   Every output is registered from the current state, so a pulse sampled on
//   edge N is visible on the outputs after edge N+1.
//
// Parameters
//   FLASH_TICKS  clk cycles per blink half-period in FLASH (>=1)
//   FLASH_COUNT  full blink cycles (dark+lit) before returning to IDLE (>=1)
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   synchronous reset, active-high
//   start      in   1-cycle pulse, begin a new game (IDLE only)
//   score_inc  in   1-cycle pulse, add 1 to the live score (PLAY only)
//   game_over  in   1-cycle pulse, end the current game (PLAY only)
//   digit3..0  out  BCD digits, digit3 = thousands (leftmost)
//   blank      out  per-digit blank, bit i darkens digit i
//   playing    out  high while in PLAY
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits are blanked in
//   IDLE/PLAY and in the lit half of FLASH (units digit is never blanked).
//   When undefined, all four digits are lit except during FLASH dark halves.
// -----------------------------------------------------------------------------
module score_sequencer #(
  parameter int FLASH_TICKS = 25_000_000,
  parameter int FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       score_inc,
  input  logic       game_over,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] blank,
  output logic       playing
);

  localparam int NUM_DIGITS = 4;
  localparam int TICK_W     = $clog2(FLASH_TICKS + 1);
  localparam int HALF_W     = $clog2(2 * FLASH_COUNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FLASH_TICKS - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_FLASH = 2'd2
  } state_t;

  state_t                         state;
  logic [NUM_DIGITS-1:0][3:0]     score, best;
  logic [TICK_W-1:0]              tick_cnt;
  logic [HALF_W-1:0]              half_cnt;

  logic [NUM_DIGITS-1:0][3:0]     disp_q;
  logic [NUM_DIGITS-1:0]          blank_q;
  logic                           playing_q;

  // ---------------------------------------------------------------------------
  // BCD increment: ripple carry through the digits. A carry out of the top
  // digit means every digit was 9, in which case the score saturates.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0]     score_plus1;
  logic [NUM_DIGITS-1:0][3:0]     score_next;
  logic [NUM_DIGITS:0]            carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_inc
    assign score_plus1[i] = !carry[i]          ? score[i] :
                            (score[i] == 4'd9) ? 4'd0     :
                                                 score[i] + 4'd1;
    assign carry[i+1]     = carry[i] & (score[i] == 4'd9);
  end

  assign score_next = carry[NUM_DIGITS] ? score : score_plus1;

  // ---------------------------------------------------------------------------
  // Value on the display for the current state, and the mask applied while
  // the display is "lit".
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0]     disp;
  logic [NUM_DIGITS-1:0]          lit_mask;
  logic                           flash_dark;

  assign disp       = (state == S_IDLE) ? best : score;
  // Even half-periods are dark, so the blink starts dark.
  assign flash_dark = (state == S_FLASH) && !half_cnt[0];

`ifdef LEADING_ZERO_BLANK_EN
  // lead[i] is set when digit i and every digit above it are zero.
  logic [NUM_DIGITS:1] lead;
  assign lead[NUM_DIGITS] = 1'b1;
  for (genvar i = NUM_DIGITS - 1; i >= 1; i--) begin : g_lz
    assign lead[i]     = lead[i+1] & (disp[i] == 4'd0);
    assign lit_mask[i] = lead[i];
  end
  assign lit_mask[0] = 1'b0;
`else
  assign lit_mask = '0;
`endif

  // ---------------------------------------------------------------------------
  // State, scores, flash counters and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      score     <= '0;
      best      <= '0;
      tick_cnt  <= '0;
      half_cnt  <= '0;
      disp_q    <= '0;
      blank_q   <= '0;
      playing_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start wins over anything else arriving with it
          if (start) begin
            score <= '0;
            state <= S_PLAY;
          end
        end

        S_PLAY: begin
          // an increment coinciding with game_over still counts
          if (score_inc) score <= score_next;
          if (game_over) begin
            state    <= S_FLASH;
            tick_cnt <= '0;
            half_cnt <= '0;
          end
        end

        S_FLASH: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              half_cnt <= '0;
              state    <= S_IDLE;
              // packed BCD compares correctly as a plain binary value;
              // a tie keeps the existing best
              if (score > best) best <= score;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      disp_q    <= disp;
      blank_q   <= flash_dark ? '1 : lit_mask;
      playing_q <= (state == S_PLAY);
    end
  end

  assign digit3  = disp_q[3];
  assign digit2  = disp_q[2];
  assign digit1  = disp_q[1];
  assign digit0  = disp_q[0];
  assign blank   = blank_q;
  assign playing = playing_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Scoreboard bench for score_sequencer (FLASH_TICKS=4, FLASH_COUNT=2).
// Stimulus pushes the expected display state for a given cycle into a queue;
// a monitor on the falling edge pops and compares when that cycle arrives.
module tb_score_sequencer;

  localparam int FT = 4;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, score_inc, game_over;
  logic [3:0] digit3, digit2, digit1, digit0, blank;
  logic       playing;

  score_sequencer #(.FLASH_TICKS(FT), .FLASH_COUNT(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .score_inc(score_inc),
    .game_over(game_over), .digit3(digit3), .digit2(digit2),
    .digit1(digit1), .digit0(digit0), .blank(blank), .playing(playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic        ply;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: slot cycle %0d passed (now %0d)", e.name, e.cyc, cyc);
      end else if ({digit3, digit2, digit1, digit0} !== e.dig ||
                   blank !== e.blk || playing !== e.ply) begin
        errors++;
        $display("FAIL %s @%0d: got digits=%h blank=%b playing=%b, want digits=%h blank=%b playing=%b",
                 e.name, cyc, {digit3, digit2, digit1, digit0}, blank, playing,
                 e.dig, e.blk, e.ply);
      end
    end
  end

  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic void expect_at(input int c, input logic [15:0] d,
                                    input logic [3:0] b, input logic p,
                                    input string name);
    exp_t x;
    x.cyc = c; x.dig = d; x.blk = b; x.ply = p; x.name = name;
    sb.push_back(x);
  endfunction

  // Expected FLASH waveform after a game_over sampled on edge c+1:
  // outputs at c+2 .. c+1+2*FC*FT blink dark-first, then IDLE showing best.
  function automatic void push_flash(input int c, input logic [15:0] d,
                                     input int upto, input logic [15:0] best_after);
    for (int k = 2; k <= upto; k++) begin
      if (k <= 2 * FC * FT + 1)
        expect_at(c + k, d, (((k - 2) / FT) % 2 == 0) ? 4'hF : 4'h0, 1'b0, "flash");
      else
        expect_at(c + k, best_after, 4'h0, 1'b0, "flash_to_idle");
    end
  endfunction

  task automatic step(input logic s, input logic i, input logic g);
    @(posedge clk); #1;
    start = s; score_inc = i; game_over = g;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; score_inc = 1'b0; game_over = 1'b0;
    expect_at(cyc + 1, 16'h0000, 4'h0, 1'b0, name);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; score_inc = 1'b0; game_over = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(cyc, 16'h0000, 4'h0, 1'b0, "reset_state");

    // pulses other than start are ignored in IDLE
    step(0, 1, 0); step(0, 0, 1); step(0, 1, 1);
    expect_at(cyc + 2, 16'h0000, 4'h0, 1'b0, "idle_ignore");
    step(0, 0, 0);
    expect_at(cyc + 3, 16'h0000, 4'h0, 1'b0, "idle_ignore2");
    idle_until(cyc + 3);

    // counting, carries and saturation
    step(1, 0, 0);
    expect_at(cyc + 2, 16'h0000, 4'h0, 1'b1, "start_play");
    for (int k = 1; k <= 10000; k++) begin
      step(0, 1, 0);
      if (k == 3 || k == 10 || k == 100 || k == 999 || k == 1000 ||
          k == 9999 || k == 10000)
        expect_at(cyc + 2, bcd((k > 9999) ? 9999 : k), 4'h0, 1'b1, "inc");
    end
    step(0, 0, 0);
    do_reset("rst_mid_play");

    // game 1: ends with inc+game_over together at 0005 -> 0006
    step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    expect_at(cyc + 2, 16'h0005, 4'h0, 1'b1, "score5");
    step(0, 1, 1);
    c = cyc;
    push_flash(c, 16'h0006, 2 * FC * FT + 2, 16'h0006);
    idle_until(c + 2 * FC * FT + 2);

    // game 2: ends at 0004, start during FLASH ignored, best stays 0006
    step(1, 0, 0);
    expect_at(cyc + 2, 16'h0000, 4'h0, 1'b1, "restart_clear");
    repeat (4) step(0, 1, 0);
    step(0, 0, 1);
    c = cyc;
    push_flash(c, 16'h0004, 2 * FC * FT + 2, 16'h0006);
    expect_at(c + 2 * FC * FT + 4, 16'h0006, 4'h0, 1'b0, "best_kept");
    step(0, 0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    idle_until(c + 2 * FC * FT + 4);

    // game 3: reset in the middle of FLASH drops best
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    c = cyc;
    push_flash(c, 16'h0001, 4, 16'h0000);
    idle_until(c + 4);
    do_reset("rst_mid_flash");
    expect_at(cyc + 3, 16'h0000, 4'h0, 1'b0, "best_lost");
    idle_until(cyc + 4);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
